// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, branch flush redirect and multicycle-op tracking.
// Optional multicycle watchdog enabled by defining PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_me,
  input  logic        mc_start,
  input  logic        mc_done,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        mc_busy,
  output logic [7:0]  mc_cycles,
  output logic        mc_timeout
);

  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_count;
  logic [31:0] r_flush_pc;
  logic [7:0]  r_mc_cycles;
  logic        r_mc_busy;
  logic        w_mc_hold;
  logic        w_timeout;
  logic        w_take_branch;
  logic [5:0]  w_stall;

  assign w_mc_hold = (r_state == MC_WAIT) && !mc_done;

`ifdef PIPE_CTRL_TIMEOUT_EN
  assign w_timeout = (r_state == MC_WAIT) && !mc_done && (r_count == 8'(TIMEOUT_CYCLES));
`else
  // Parameter still referenced so the default build has no unused parameter.
  assign w_timeout = 1'b0 & (r_count == 8'(TIMEOUT_CYCLES));
`endif

  // Highest stalled stage wins; everything upstream of it holds as well.
  always_comb begin
    w_stall = 6'b000000;
    if (stallreq_me)      w_stall = 6'b011111;
    else if (w_mc_hold)   w_stall = 6'b001111;
    else if (stallreq_id) w_stall = 6'b000111;
    else if (stallreq_if) w_stall = 6'b000011;
  end

  always_comb begin
    w_next        = r_state;
    w_take_branch = 1'b0;
    case (r_state)
      RUN: begin
        if (mc_start) begin
          w_next = MC_WAIT;
        end else if (branch_flag && !w_stall[3]) begin
          w_next        = FLUSH;
          w_take_branch = 1'b1;
        end
      end
      MC_WAIT: begin
        if (mc_done || w_timeout) w_next = RUN;
      end
      FLUSH: begin
        if (branch_flag && !w_stall[3]) begin
          w_next        = FLUSH;
          w_take_branch = 1'b1;
        end else begin
          w_next = RUN;
        end
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_count     <= 8'd0;
      r_flush_pc  <= 32'h0;
      r_mc_cycles <= 8'd0;
      r_mc_busy   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mc_busy <= (w_next == MC_WAIT);
      if (r_state == RUN && mc_start) begin
        r_count <= 8'd1;
      end else if (r_state == MC_WAIT && r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
      if (w_take_branch) r_flush_pc <= branch_target;
      // A done in the limit cycle reports the real count, not the abort marker.
      if (r_state == MC_WAIT && mc_done) begin
        r_mc_cycles <= r_count;
      end else if (w_timeout) begin
        r_mc_cycles <= 8'hFF;
      end
    end
  end

  assign stall      = w_stall;
  assign flush      = (r_state == FLUSH);
  assign flush_pc   = r_flush_pc;
  assign mc_busy    = r_mc_busy;
  assign mc_cycles  = r_mc_cycles;
  assign mc_timeout = w_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table plus multicycle, timeout and reset sequences.
// Expectations for the watchdog follow PIPE_CTRL_TIMEOUT_EN when it is defined.
module tb_pipe_ctrl;

  logic        clock;
  logic        reset;
  logic        stallReqIf;
  logic        stallReqId;
  logic        stallReqMe;
  logic        mcStart;
  logic        mcDone;
  logic        branchFlag;
  logic [31:0] branchTarget;
  logic [5:0]  stallOut;
  logic        flushOut;
  logic [31:0] flushPc;
  logic        mcBusy;
  logic [7:0]  mcCycles;
  logic        mcTimeout;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic        me;
    logic        id;
    logic        ifs;
    logic        start;
    logic        done;
    logic        br;
    logic [31:0] tgt;
    logic [5:0]  expStall;
    logic        expFlush;
    logic [31:0] expPc;
    logic        expBusy;
    logic [7:0]  expCycles;
    logic        expTimeout;
  } vec_t;

  vec_t vecs [21];

  pipe_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clock),
    .rst          (reset),
    .stallreq_if  (stallReqIf),
    .stallreq_id  (stallReqId),
    .stallreq_me  (stallReqMe),
    .mc_start     (mcStart),
    .mc_done      (mcDone),
    .branch_flag  (branchFlag),
    .branch_target(branchTarget),
    .stall        (stallOut),
    .flush        (flushOut),
    .flush_pc     (flushPc),
    .mc_busy      (mcBusy),
    .mc_cycles    (mcCycles),
    .mc_timeout   (mcTimeout)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic applyStimulus(input logic me, input logic id, input logic ifs,
                               input logic start, input logic done, input logic br,
                               input logic [31:0] tgt);
    stallReqMe   = me;
    stallReqId   = id;
    stallReqIf   = ifs;
    mcStart      = start;
    mcDone       = done;
    branchFlag   = br;
    branchTarget = tgt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    else
      passCount++;
  endtask

  task automatic idleCycle();
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
  endtask

  // Main sequence: reset, vector table, then multicycle corner cases.
  initial begin
    vecs[0]  = '{0,0,0,0,0,0,32'h0,    6'b000000,0,32'h0,   0,8'd0,0};
    vecs[1]  = '{0,1,0,0,0,0,32'h0,    6'b000111,0,32'h0,   0,8'd0,0};
    vecs[2]  = '{0,0,0,0,0,0,32'h0,    6'b000000,0,32'h0,   0,8'd0,0};
    vecs[3]  = '{0,0,1,0,0,0,32'h0,    6'b000011,0,32'h0,   0,8'd0,0};
    vecs[4]  = '{0,1,1,0,0,0,32'h0,    6'b000111,0,32'h0,   0,8'd0,0};
    vecs[5]  = '{1,1,0,0,0,0,32'h0,    6'b011111,0,32'h0,   0,8'd0,0};
    vecs[6]  = '{0,0,0,0,0,1,32'h400,  6'b000000,0,32'h0,   0,8'd0,0};
    vecs[7]  = '{0,0,0,0,0,0,32'h0,    6'b000000,1,32'h400, 0,8'd0,0};
    vecs[8]  = '{0,0,0,0,0,0,32'h0,    6'b000000,0,32'h400, 0,8'd0,0};
    vecs[9]  = '{1,0,0,0,0,1,32'h800,  6'b011111,0,32'h400, 0,8'd0,0};
    vecs[10] = '{0,0,0,0,0,0,32'h0,    6'b000000,0,32'h400, 0,8'd0,0};
    vecs[11] = '{0,0,0,0,0,1,32'h800,  6'b000000,0,32'h400, 0,8'd0,0};
    vecs[12] = '{0,0,0,0,0,1,32'hC00,  6'b000000,1,32'h800, 0,8'd0,0};
    vecs[13] = '{0,0,0,0,0,0,32'h0,    6'b000000,1,32'hC00, 0,8'd0,0};
    vecs[14] = '{0,0,0,0,0,0,32'h0,    6'b000000,0,32'hC00, 0,8'd0,0};
    vecs[15] = '{0,0,0,1,0,1,32'h1000, 6'b000000,0,32'hC00, 0,8'd0,0};
    vecs[16] = '{0,1,0,0,0,0,32'h0,    6'b001111,0,32'hC00, 1,8'd0,0};
    vecs[17] = '{1,0,0,0,0,1,32'h2000, 6'b011111,0,32'hC00, 1,8'd0,0};
    vecs[18] = '{0,0,0,0,0,0,32'h0,    6'b001111,0,32'hC00, 1,8'd0,0};
    vecs[19] = '{0,0,0,0,1,0,32'h0,    6'b000000,0,32'hC00, 1,8'd0,0};
    vecs[20] = '{0,0,0,0,0,0,32'h0,    6'b000000,0,32'hC00, 0,8'd4,0};

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    checkOutput("reset_stall", 32'(stallOut), 32'h0);
    checkOutput("reset_flush", 32'(flushOut), 32'h0);
    checkOutput("reset_busy", 32'(mcBusy), 32'h0);
    checkOutput("reset_cycles", 32'(mcCycles), 32'h0);
    checkOutput("reset_timeout", 32'(mcTimeout), 32'h0);
    stallReqId = 1'b1;
    #1;
    checkOutput("reset_stall_id", 32'(stallOut), 32'b000111);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i].me, vecs[i].id, vecs[i].ifs, vecs[i].start,
                    vecs[i].done, vecs[i].br, vecs[i].tgt);
      #1;
      checkOutput($sformatf("v%0d_stall", i), 32'(stallOut), 32'(vecs[i].expStall));
      checkOutput($sformatf("v%0d_flush", i), 32'(flushOut), 32'(vecs[i].expFlush));
      checkOutput($sformatf("v%0d_flush_pc", i), flushPc, vecs[i].expPc);
      checkOutput($sformatf("v%0d_busy", i), 32'(mcBusy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d_cycles", i), 32'(mcCycles), 32'(vecs[i].expCycles));
      checkOutput($sformatf("v%0d_timeout", i), 32'(mcTimeout), 32'(vecs[i].expTimeout));
    end

    // Multicycle op with no done: watchdog abort or indefinite wait.
    @(negedge clock);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h0);
    #1;
    checkOutput("wd_start_stall", 32'(stallOut), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      idleCycle();
      checkOutput($sformatf("wd_c%0d_stall", k), 32'(stallOut), 32'b001111);
      checkOutput($sformatf("wd_c%0d_timeout", k), 32'(mcTimeout), 32'h0);
    end
    idleCycle();
    checkOutput("wd_c4_stall", 32'(stallOut), 32'b001111);
`ifdef PIPE_CTRL_TIMEOUT_EN
    checkOutput("wd_c4_timeout", 32'(mcTimeout), 32'h1);
    idleCycle();
    checkOutput("wd_after_stall", 32'(stallOut), 32'h0);
    checkOutput("wd_after_busy", 32'(mcBusy), 32'h0);
    checkOutput("wd_after_timeout", 32'(mcTimeout), 32'h0);
    checkOutput("wd_after_cycles", 32'(mcCycles), 32'hFF);
`else
    checkOutput("wd_c4_timeout", 32'(mcTimeout), 32'h0);
    for (int k = 5; k < 300; k++) begin
      idleCycle();
      if (k == 10 || k == 299) begin
        checkOutput($sformatf("wait_c%0d_stall", k), 32'(stallOut), 32'b001111);
        checkOutput($sformatf("wait_c%0d_busy", k), 32'(mcBusy), 32'h1);
        checkOutput($sformatf("wait_c%0d_timeout", k), 32'(mcTimeout), 32'h0);
      end
    end
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h0);
    #1;
    checkOutput("sat_done_stall", 32'(stallOut), 32'h0);
    idleCycle();
    checkOutput("sat_cycles", 32'(mcCycles), 32'hFF);
    checkOutput("sat_busy", 32'(mcBusy), 32'h0);
`endif

    // Reset between edges while in MC_WAIT.
    @(negedge clock);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h0);
    idleCycle();
    idleCycle();
    checkOutput("mc_pre_reset_busy", 32'(mcBusy), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("mc_reset_busy", 32'(mcBusy), 32'h0);
    checkOutput("mc_reset_stall", 32'(stallOut), 32'h0);
    checkOutput("mc_reset_cycles", 32'(mcCycles), 32'h0);
    checkOutput("mc_reset_flush_pc", flushPc, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Reset between edges while in FLUSH: redirect is dropped.
    @(negedge clock);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h3000);
    idleCycle();
    checkOutput("fl_pre_reset_flush", 32'(flushOut), 32'h1);
    checkOutput("fl_pre_reset_pc", flushPc, 32'h3000);
    reset = 1'b1;
    #1;
    checkOutput("fl_reset_flush", 32'(flushOut), 32'h0);
    checkOutput("fl_reset_pc", flushPc, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idleCycle();
    checkOutput("fl_post_reset_flush", 32'(flushOut), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the multicycle watchdog limit in cycles (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port stallreq_if  input  1  fetch stage cannot advance.
REQ-005 SHALL have port stallreq_id  input  1  decode stage cannot advance (load-use hazard).
REQ-006 SHALL have port stallreq_me  input  1  memory stage cannot advance (data bus wait).
REQ-007 SHALL have port mc_start  input  1  one-cycle pulse; EX issued a multicycle op (AES round unit).
REQ-008 SHALL have port mc_done  input  1  one-cycle pulse; multicycle unit result valid this cycle.
REQ-009 SHALL have port branch_flag  input  1  EX resolved a taken branch/jump this cycle.
REQ-010 SHALL have port branch_target  input  32  redirect address qualified by branch_flag.
REQ-011 SHALL have port stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/ME, bit4 ME/WB, bit5 WB.
REQ-012 SHALL have port flush  output  1  kill IF/ID and ID/EX contents and load PC from flush_pc.
REQ-013 SHALL have port flush_pc  output  32  redirect address, valid while flush=1.
REQ-014 SHALL have port mc_busy  output  1  high while in MC_WAIT.
REQ-015 SHALL have port mc_cycles  output  8  duration of the most recent multicycle op, saturating at 255.
REQ-016 SHALL have port mc_timeout  output  1  one-cycle watchdog abort pulse.

Function
REQ-017 SHALL implement FSM states RUN, MC_WAIT, FLUSH, all transitions on clk rising edge.
REQ-018 stall SHALL be combinational from inputs and state, priority: stallreq_me -> 6'b011111; else mc_hold -> 6'b001111; else stallreq_id -> 6'b000111; else stallreq_if -> 6'b000011; else 6'b000000.
REQ-019 mc_hold SHALL equal (state==MC_WAIT && !mc_done); the EX result advances in the mc_done cycle.
REQ-020 stall[5] SHALL always be 0.
REQ-021 RUN: mc_start=1 -> MC_WAIT, counter cleared to 1; mc_start has priority over a simultaneous branch_flag, which is ignored.
REQ-022 RUN or FLUSH: branch_flag=1 with stall[3]=0 -> FLUSH; branch_target captured into flush_pc.
REQ-023 branch_flag with stall[3]=1 SHALL be ignored; EX re-presents it once released.
REQ-024 FLUSH SHALL assert flush=1 for exactly that cycle, then return to RUN unless a new accepted branch_flag keeps it in FLUSH with the new target.
REQ-025 flush SHALL be 0 in RUN and MC_WAIT; flush_pc SHALL hold its last value when flush=0.
REQ-026 MC_WAIT: counter increments each cycle, saturating at 255; mc_done -> RUN, mc_cycles loaded with counter value; mc_start ignored.
REQ-027 mc_busy SHALL equal (state==MC_WAIT) and be registered.

Reset
REQ-028 rst=1 SHALL immediately force state RUN, flush=0, flush_pc=32'h0, counter=0, mc_cycles=0, mc_busy=0, mc_timeout=0, independent of clk.
REQ-029 stall SHALL follow REQ-018 from inputs while rst=1, with no mc_hold contribution since state is RUN.
REQ-030 Reset in MC_WAIT or FLUSH SHALL abandon the op or redirect without a flush pulse.

Configuration
REQ-031 With macro PIPE_CTRL_TIMEOUT_EN defined: in MC_WAIT, when counter reaches TIMEOUT_CYCLES without mc_done, mc_timeout SHALL pulse 1 cycle, mc_cycles SHALL load 8'hFF, FSM -> RUN; mc_done in that same cycle takes priority, with no timeout.
REQ-032 Without PIPE_CTRL_TIMEOUT_EN: mc_timeout SHALL be constant 0, and MC_WAIT waits indefinitely for mc_done.

Verification
REQ-033 Idle, stallreq_id=1 one cycle -> stall=6'b000111 that cycle, 0 next.
REQ-034 mc_start at cycle 10, mc_done at cycle 15 -> mc_busy 11..15, stall=6'b001111 cycles 11..14, stall=0 cycle 15, mc_cycles=5 from cycle 16.
REQ-035 branch_flag=1, branch_target=32'h0000_0400, no stalls -> next cycle flush=1, flush_pc=32'h400; following cycle flush=0.
REQ-036 stallreq_me=1 during MC_WAIT -> stall=6'b011111; branch_flag in that cycle -> no flush.
REQ-037 TIMEOUT_EN, TIMEOUT_CYCLES=4, mc_start with no mc_done -> mc_timeout pulse on the 4th MC_WAIT cycle, mc_cycles=8'hFF, stall=0 afterwards; without the macro, stall holds 6'b001111.
REQ-038 rst asserted mid-MC_WAIT between clock edges -> mc_busy=0 and stall=0 before the next edge.
